// File: rtl/gpr_writeback_arbiter_if.sv
// Write-side bus of the GPR writeback arbiter: pipeline WB source,
// long-latency (aux) source with valid/ready, hazard queries and the
// register file write port. The arbiter takes the slave view.
interface gpr_writeback_arbiter_if #(
  parameter int COUNT_WIDTH = 2
);
  logic                   wb_valid;
  logic [4:0]             wb_address;
  logic [31:0]            wb_data;
  logic                   aux_valid;
  logic [4:0]             aux_address;
  logic [31:0]            aux_data;
  logic                   aux_ready;
  logic [4:0]             query_address_1;
  logic [4:0]             query_address_2;
  logic                   pending_1;
  logic                   pending_2;
  logic                   write_enable;
  logic [4:0]             write_address;
  logic [31:0]            write_data;
  logic [COUNT_WIDTH-1:0] queue_count;

  modport master (
    output wb_valid, wb_address, wb_data,
    output aux_valid, aux_address, aux_data,
    output query_address_1, query_address_2,
    input  aux_ready, pending_1, pending_2,
    input  write_enable, write_address, write_data, queue_count
  );

  modport slave (
    input  wb_valid, wb_address, wb_data,
    input  aux_valid, aux_address, aux_data,
    input  query_address_1, query_address_2,
    output aux_ready, pending_1, pending_2,
    output write_enable, write_address, write_data, queue_count
  );
endinterface

// File: rtl/gpr_writeback_arbiter.sv
// Merges the pipeline WB stage and a long-latency unit onto the single
// register file write port. Pipeline writes always win; aux results wait
// in a small FIFO and drain into idle slots. Queued destinations are
// reported as pending hazards until they are committed.
module gpr_writeback_arbiter #(
  parameter int QUEUE_DEPTH = 2,
  parameter int COUNT_WIDTH = 2
) (
  input logic                     system_clock,
  input logic                     system_reset_n,
  gpr_writeback_arbiter_if.slave  bus
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(QUEUE_DEPTH);

  // FIFO storage and bookkeeping
  logic [4:0]             entry_addr_q [QUEUE_DEPTH];
  logic [31:0]            entry_data_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] entry_valid_q, entry_valid_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Registered write port
  logic                   we_q, we_d;
  logic [4:0]             wa_q, wa_d;
  logic [31:0]            wd_q, wd_d;

  logic wb_take, fifo_empty, aux_ready, push, pop;
  logic pend_1, pend_2;

  // Arbitration decisions and next-state for the FIFO and write port
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // a value unassigned; that is what keeps this block free of latches.
    wb_take       = bus.wb_valid && (bus.wb_address != 5'd0);
    fifo_empty    = (count_q == '0);
    aux_ready     = (count_q < DEPTH_C);
    push          = bus.aux_valid && aux_ready && (bus.aux_address != 5'd0);
    pop           = !wb_take && !fifo_empty;

    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    entry_valid_d = entry_valid_q;
    we_d          = 1'b0;
    wa_d          = wa_q;
    wd_d          = wd_q;

    if (wb_take) begin
      we_d = 1'b1;
      wa_d = bus.wb_address;
      wd_d = bus.wb_data;
    end else if (pop) begin
      we_d = 1'b1;
      wa_d = entry_addr_q[rd_ptr_q];
      wd_d = entry_data_q[rd_ptr_q];
    end

    // Push and pop never target the same slot: push needs a non-full
    // queue, pop a non-empty one, and the pointers only coincide at those
    // two extremes.
    if (pop) begin
      entry_valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d                = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      entry_valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d                = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Hazard lookup: any valid queued entry matching a non-zero query
  always_comb begin
    pend_1 = 1'b0;
    pend_2 = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (entry_valid_q[i] && (entry_addr_q[i] == bus.query_address_1))
        pend_1 = 1'b1;
      if (entry_valid_q[i] && (entry_addr_q[i] == bus.query_address_2))
        pend_2 = 1'b1;
    end
    if (bus.query_address_1 == 5'd0) pend_1 = 1'b0;
    if (bus.query_address_2 == 5'd0) pend_2 = 1'b0;
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      entry_valid_q <= '0;
      we_q          <= 1'b0;
      wa_q          <= 5'd0;
      wd_q          <= 32'd0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      entry_valid_q <= entry_valid_d;
      we_q          <= we_d;
      wa_q          <= wa_d;
      wd_q          <= wd_d;
    end
  end

  // FIFO payload storage, written on accepted non-r0 aux results
  always_ff @(posedge system_clock) begin
    // NOTE: the payload arrays carry no reset; entry_valid_q and count_q
    // already make stale contents invisible, and unreset storage maps
    // onto plain RAM/flops without a reset tree.
    if (push) begin
      entry_addr_q[wr_ptr_q] <= bus.aux_address;
      entry_data_q[wr_ptr_q] <= bus.aux_data;
    end
  end

  assign bus.aux_ready     = aux_ready;
  assign bus.pending_1     = pend_1;
  assign bus.pending_2     = pend_2;
  assign bus.write_enable  = we_q;
  assign bus.write_address = wa_q;
  assign bus.write_data    = wd_q;
  assign bus.queue_count   = count_q;

endmodule

// File: tb/tb_gpr_writeback_arbiter.sv
// Directed bench for gpr_writeback_arbiter. Inputs change 1 time unit
// after each rising edge; outputs are checked at that same point.
module tb_gpr_writeback_arbiter;

  logic system_clock   = 1'b0;
  logic system_reset_n = 1'b0;

  gpr_writeback_arbiter_if #(.COUNT_WIDTH(2)) bus ();

  gpr_writeback_arbiter #(
    .QUEUE_DEPTH (2),
    .COUNT_WIDTH (2)
  ) dut (
    .system_clock   (system_clock),
    .system_reset_n (system_reset_n),
    .bus            (bus)
  );

  always #5 system_clock = ~system_clock;

  int total = 0;
  int bad   = 0;

  // Register file fed by the write port, plus a watch for r0 writes
  logic [31:0] gpr_model [32];
  int          zero_writes = 0;

  initial for (int i = 0; i < 32; i++) gpr_model[i] = 32'd0;

  always @(posedge system_clock) begin
    if (bus.write_enable) begin
      gpr_model[bus.write_address] <= bus.write_data;
      if (bus.write_address == 5'd0) zero_writes <= zero_writes + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
    check({tag, ".we"}, 32'(bus.write_enable), 32'(we));
    check({tag, ".wa"}, 32'(bus.write_address), 32'(wa));
    check({tag, ".wd"}, bus.write_data, wd);
  endtask

  initial begin
    bus.wb_valid        = 1'b0;
    bus.wb_address      = 5'd0;
    bus.wb_data         = 32'd0;
    bus.aux_valid       = 1'b0;
    bus.aux_address     = 5'd0;
    bus.aux_data        = 32'd0;
    bus.query_address_1 = 5'd0;
    bus.query_address_2 = 5'd0;

    // Reset state
    tick(); tick();
    check_port("rst", 1'b0, 5'd0, 32'd0);
    check("rst.count", 32'(bus.queue_count), 32'd0);
    check("rst.ready", 32'(bus.aux_ready), 32'd1);
    system_reset_n = 1'b1;
    tick();

    // Single pipeline write to r3
    bus.wb_valid = 1'b1; bus.wb_address = 5'd3; bus.wb_data = 32'hA5A5A5A5;
    tick();
    check_port("wb3", 1'b1, 5'd3, 32'hA5A5A5A5);
    bus.wb_valid = 1'b0;
    tick();
    check_port("wb3.idle", 1'b0, 5'd3, 32'hA5A5A5A5);
    check("wb3.gpr", gpr_model[3], 32'hA5A5A5A5);

    // Single aux push to r7 with WB idle
    bus.aux_valid = 1'b1; bus.aux_address = 5'd7; bus.aux_data = 32'h00000007;
    bus.query_address_1 = 5'd7; bus.query_address_2 = 5'd6;
    #1;
    check("aux7.ready", 32'(bus.aux_ready), 32'd1);
    tick();
    bus.aux_valid = 1'b0;
    #1;
    check("aux7.count1", 32'(bus.queue_count), 32'd1);
    check("aux7.pend1", 32'(bus.pending_1), 32'd1);
    check("aux7.pend2", 32'(bus.pending_2), 32'd0);
    check("aux7.noearly", 32'(bus.write_enable), 32'd0);
    tick();
    check_port("aux7.wr", 1'b1, 5'd7, 32'h00000007);
    check("aux7.count0", 32'(bus.queue_count), 32'd0);
    check("aux7.pend1clr", 32'(bus.pending_1), 32'd0);
    tick();
    check("aux7.idle", 32'(bus.write_enable), 32'd0);

    // WB holds r4 for four cycles while aux offers r8, r9, r10
    bus.wb_valid = 1'b1; bus.wb_address = 5'd4; bus.wb_data = 32'h44;
    bus.aux_valid = 1'b1; bus.aux_address = 5'd8; bus.aux_data = 32'h8;
    bus.query_address_1 = 5'd9; bus.query_address_2 = 5'd8;
    tick();                                                  // E1: push r8
    check_port("bp.e1", 1'b1, 5'd4, 32'h44);
    check("bp.e1.count", 32'(bus.queue_count), 32'd1);
    check("bp.e1.pend2", 32'(bus.pending_2), 32'd1);
    bus.aux_address = 5'd9; bus.aux_data = 32'h9;
    tick();                                                  // E2: push r9
    check_port("bp.e2", 1'b1, 5'd4, 32'h44);
    check("bp.e2.count", 32'(bus.queue_count), 32'd2);
    check("bp.e2.ready", 32'(bus.aux_ready), 32'd0);
    check("bp.e2.pend1", 32'(bus.pending_1), 32'd1);
    bus.aux_address = 5'd10; bus.aux_data = 32'hA;
    tick();                                                  // E3: full, stalled
    check_port("bp.e3", 1'b1, 5'd4, 32'h44);
    check("bp.e3.count", 32'(bus.queue_count), 32'd2);
    check("bp.e3.ready", 32'(bus.aux_ready), 32'd0);
    tick();                                                  // E4: last wb write
    check_port("bp.e4", 1'b1, 5'd4, 32'h44);
    bus.wb_valid = 1'b0;
    #1;
    check("bp.e4.readyfull", 32'(bus.aux_ready), 32'd0);
    tick();                                                  // E5: pop r8
    check_port("bp.e5", 1'b1, 5'd8, 32'h8);
    check("bp.e5.count", 32'(bus.queue_count), 32'd1);
    check("bp.e5.ready", 32'(bus.aux_ready), 32'd1);
    check("bp.e5.pend2", 32'(bus.pending_2), 32'd0);
    tick();                                                  // E6: pop r9, push r10
    check_port("bp.e6", 1'b1, 5'd9, 32'h9);
    check("bp.e6.count", 32'(bus.queue_count), 32'd1);
    bus.aux_valid = 1'b0;
    tick();                                                  // E7: pop r10
    check_port("bp.e7", 1'b1, 5'd10, 32'hA);
    check("bp.e7.count", 32'(bus.queue_count), 32'd0);
    tick();
    check("bp.e8.idle", 32'(bus.write_enable), 32'd0);

    // WB to r0 leaves the slot free for a queued r5
    bus.aux_valid = 1'b1; bus.aux_address = 5'd5; bus.aux_data = 32'h55;
    bus.query_address_1 = 5'd5;
    tick();
    bus.aux_valid = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_address = 5'd0; bus.wb_data = 32'hDEADBEEF;
    #1;
    check("r0.count", 32'(bus.queue_count), 32'd1);
    check("r0.pend1", 32'(bus.pending_1), 32'd1);
    tick();
    check_port("r0.drain", 1'b1, 5'd5, 32'h55);
    check("r0.pend1clr", 32'(bus.pending_1), 32'd0);
    tick();
    check_port("r0.idle", 1'b0, 5'd5, 32'h55);
    bus.wb_valid = 1'b0;

    // Aux push to r0 completes the handshake but is dropped
    bus.aux_valid = 1'b1; bus.aux_address = 5'd0; bus.aux_data = 32'h99;
    bus.query_address_1 = 5'd0; bus.query_address_2 = 5'd0;
    #1;
    check("ax0.ready", 32'(bus.aux_ready), 32'd1);
    tick();
    bus.aux_valid = 1'b0;
    #1;
    check("ax0.count", 32'(bus.queue_count), 32'd0);
    check("ax0.pend1", 32'(bus.pending_1), 32'd0);
    check("ax0.pend2", 32'(bus.pending_2), 32'd0);
    tick();
    check("ax0.nowrite", 32'(bus.write_enable), 32'd0);

    // Fill with r11/r12 behind WB traffic, then reset mid-queue
    bus.wb_valid = 1'b1; bus.wb_address = 5'd1; bus.wb_data = 32'h11;
    bus.aux_valid = 1'b1; bus.aux_address = 5'd11; bus.aux_data = 32'hB;
    bus.query_address_1 = 5'd11; bus.query_address_2 = 5'd12;
    tick();
    bus.aux_address = 5'd12; bus.aux_data = 32'hC;
    tick();
    bus.wb_valid = 1'b0; bus.aux_valid = 1'b0;
    #1;
    check("fill.count", 32'(bus.queue_count), 32'd2);
    check("fill.pend1", 32'(bus.pending_1), 32'd1);
    check("fill.pend2", 32'(bus.pending_2), 32'd1);
    system_reset_n = 1'b0;
    tick();
    system_reset_n = 1'b1;
    check_port("frst", 1'b0, 5'd0, 32'd0);
    check("frst.count", 32'(bus.queue_count), 32'd0);
    check("frst.pend1", 32'(bus.pending_1), 32'd0);
    check("frst.pend2", 32'(bus.pending_2), 32'd0);
    tick();
    check("frst.after1", 32'(bus.write_enable), 32'd0);
    tick();
    check("frst.after2", 32'(bus.write_enable), 32'd0);
    check("frst.r11", gpr_model[11], 32'd0);
    check("frst.r12", gpr_model[12], 32'd0);
    check("frst.r1", gpr_model[1], 32'h11);

    // No write ever targeted r0
    check("r0.never", 32'(zero_writes), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_writeback_arbiter.md
Name: gpr_writeback_arbiter

Overview:
- Write-side driver for general_purpose_register. It merges two write sources into the register file's single write port:
  - the in-order pipeline WB stage;
  - a long-latency unit (mul/div, later loads) with a valid/ready handshake.
- Pipeline writes always win. Long-latency results are held in a small FIFO and drain into idle write slots.
- Also reports pending-write hazards to the hazard/stall unit.

Parameters:
- QUEUE_DEPTH, 2, number of entries in the long-latency result FIFO (power of two, ≥2).
- COUNT_WIDTH, 2, width of queue_count; holds 0..QUEUE_DEPTH.

Ports:
- system_clock  input  1  single clock; all state updates on rising edge.
- system_reset_n  input  1  synchronous, active-low reset.
- wb_valid  input  1  pipeline WB stage has a result this cycle.
- wb_address  input  5  pipeline destination register.
- wb_data  input  32  pipeline result.
- aux_valid  input  1  long-latency unit offers a result.
- aux_address  input  5  long-latency destination register.
- aux_data  input  32  long-latency result.
- aux_ready  output  1  arbiter accepts the aux result this cycle.
- query_address_1  input  5  hazard query (rs).
- query_address_2  input  5  hazard query (rt).
- pending_1  output  1  query_address_1 has a queued, unwritten aux result.
- pending_2  output  1  query_address_2 has a queued, unwritten aux result.
- write_enable  output  1  to general_purpose_register.write_enable.
- write_address  output  5  to general_purpose_register.write_address.
- write_data  output  32  to general_purpose_register.write_data.
- queue_count  output  COUNT_WIDTH  occupied FIFO entries.

Behaviour:
- Reset (system_reset_n=0 at a rising edge):
  - write_enable=0, write_address=0, write_data=0.
  - FIFO emptied: queue_count=0, all entry valids cleared.
  - Takes effect even mid-drain; queued results are discarded.
- Write port outputs are registered, so write latency is 1 cycle from the deciding edge.
- Selection each cycle, evaluated before the edge, in priority order:
  1. wb_valid=1 and wb_address≠0: next write_enable=1, address/data from wb.
  2. Otherwise, FIFO non-empty: next write_enable=1, address/data from FIFO head; head is popped at this edge.
  3. Otherwise: next write_enable=0. write_address and write_data hold their previous values.
- wb_valid with wb_address=0 is treated as no pipeline write (r0 is hardwired). The FIFO may drain in that slot.
- Handshake:
  - aux_ready = (queue_count < QUEUE_DEPTH), combinational from registered state only.
  - Transfer occurs when aux_valid && aux_ready at the edge.
  - aux_ready does not consider a same-cycle pop; when full, aux_ready=0 even if the head pops this cycle.
  - aux_valid/address/data must stay stable while aux_ready=0; the arbiter does not check this.
- A transferred aux result with aux_address=0 is accepted (handshake completes) but not enqueued.
- An aux result is never written in its accept cycle. Minimum aux latency is accept edge + 1 edge to drive write_enable.
- Simultaneous push and pop on a non-empty FIFO: queue_count unchanged, order preserved (FIFO, no reordering).
- Read/write pointers are log2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
- pending_n:
  - Combinational: 1 if query_address_n≠0 and any valid FIFO entry has a matching address.
  - Includes the entry being popped this cycle. It clears the cycle after the pop edge, when the value is committed via write_enable.
- No WAW resolution between wb and queued entries; the hazard unit must stall on pending_n.
- queue_count equals pushes minus pops since reset; it never exceeds QUEUE_DEPTH and never underflows.

Test Plan:
- Reset then wb_valid=1, wb_address=3, wb_data=A5A5A5A5 for one cycle → next cycle write_enable=1, write_address=3, write_data=A5A5A5A5; following cycle write_enable=0. GPR read of r3 returns A5A5A5A5.
- aux push (addr 7, data 00000007) with wb idle → aux_ready=1; queue_count=1 for one cycle; pending_1=1 for query_address_1=7; next cycle write_enable=1, address 7; then queue_count=0, pending_1=0.
- wb_valid held high (addr 4) for 4 cycles while aux pushes addrs 8, 9, 10 → aux_ready drops to 0 after 2 accepts (queue_count=2). Writes order: r4×4, then r8, r9; r10 is accepted once aux_ready returns to 1 and is written last.
- wb_address=0 with wb_valid=1 and one queued entry (addr 5) → the queued entry is written in that slot; write_enable never asserts with address 0.
- aux push to addr 0 → aux_ready=1, queue_count stays 0, no write issued, pending_n=0.
- Fill FIFO (addrs 11, 12), assert system_reset_n=0 for one edge → queue_count=0, write_enable=0, pending_n=0. r11 and r12 are never written.
